// File: rtl/fetch_unit_if.sv
// Instruction memory fetch bus: word address + read request from the
// fetch unit, data + one-cycle completion strobe from memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  // fetch unit side
  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ready
  );

  // memory side
  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-entry prefetch buffer between a memory fetch
// side and a decoder issue side, with branch redirect and wrap-around pc.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      mem,
  output logic [31:0]       ir,
  output logic              cs,
  input  logic              dec_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    BUSY
  } issue_state_t;

  issue_state_t state;
  issue_state_t state_nxt;

  logic [31:0] buf_data;
  logic        buf_valid;
  logic        fetch_done;
  logic        issue;

  // Request a word whenever the buffer is empty; the address is always pc.
  assign mem.mem_rd   = !buf_valid && !rst;
  assign mem.mem_addr = pc;

  // A redirect in the same cycle discards the returning word.
  assign fetch_done = mem.mem_rd && mem.mem_ready && !br_valid;

  // Issue handshake: start pulse, wait for decoder to drop ready, then for it to return.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (buf_valid && dec_ready && !br_valid) begin
          issue     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!dec_ready) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dec_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Prefetch buffer, program counter, instruction register and start pulse.
  // Refill and consume are mutually exclusive: refill needs an empty buffer,
  // issue needs a full one, so no bypass from mem_rdata to ir exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      buf_valid <= 1'b0;
      ir        <= '0;
      cs        <= 1'b0;
    end else begin
      cs <= issue;
      if (issue) begin
        ir <= buf_data;
      end
      if (br_valid) begin
        pc        <= br_target;
        buf_valid <= 1'b0;
      end else if (fetch_done) begin
        buf_data  <= mem.mem_rdata;
        buf_valid <= 1'b1;
        pc        <= pc + ADDR_W'(1);
      end else if (issue) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// memory/decoder/branch traffic compared against a queue-based reference.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        dec_ready;
  logic        br_valid;
  logic [15:0] br_target;
  logic [31:0] ir;
  logic        cs;
  logic [15:0] pc;

  logic        rst2;
  logic        dec_ready2;
  logic        br_valid2;
  logic [15:0] br_target2;
  logic [31:0] ir2;
  logic        cs2;
  logic [15:0] pc2;

  fetch_unit_if #(.ADDR_W(16)) m ();
  fetch_unit_if #(.ADDR_W(16)) m2 ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem(m), .ir(ir), .cs(cs), .dec_ready(dec_ready),
    .br_valid(br_valid), .br_target(br_target), .pc(pc)
  );

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst2), .mem(m2), .ir(ir2), .cs(cs2), .dec_ready(dec_ready2),
    .br_valid(br_valid2), .br_target(br_target2), .pc(pc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // memory contents: every address holds a distinct word
  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  // ---------------- reference model ----------------
  // pc as an integer, the buffer as a queue of at most one word, and the
  // decoder handshake as a history: after an issue, the decoder must be seen
  // low at some later edge and high at a still later edge before the next.
  int unsigned m_pc = 0;
  logic [31:0] m_buf[$];
  logic [31:0] m_ir = '0;
  logic        m_cs = 1'b0;
  bit          m_rearmed = 1'b1;
  bit          m_saw_low = 1'b0;

  always @(posedge clk) begin : model
    bit empty_at_edge;
    bit issue_now;
    if (rst) begin
      m_pc = 0;
      m_buf.delete();
      m_ir = '0;
      m_cs = 1'b0;
      m_rearmed = 1'b1;
      m_saw_low = 1'b0;
    end else begin
      empty_at_edge = (m_buf.size() == 0);
      issue_now = !empty_at_edge && dec_ready && !br_valid && m_rearmed;
      m_cs = issue_now;
      if (issue_now) begin
        m_ir = m_buf.pop_front();
        m_rearmed = 1'b0;
        m_saw_low = 1'b0;
      end else if (!m_rearmed) begin
        if (m_saw_low && dec_ready) m_rearmed = 1'b1;
        else if (!dec_ready) m_saw_low = 1'b1;
      end
      if (br_valid) begin
        m_pc = br_target;
        m_buf.delete();
      end else if (empty_at_edge && m.mem_ready) begin
        m_buf.push_back(word_at(m_pc[15:0]));
        m_pc = (m_pc + 1) % 65536;
      end
    end
  end

  // ---------------- environment ----------------
  int unsigned cfg_lat_min = 0, cfg_lat_max = 0, cfg_ack_max = 0;
  int unsigned cfg_busy_min = 1, cfg_busy_max = 1, cfg_br_rate = 0;
  bit          cfg_spurious = 1'b0;
  int unsigned mem_wait = 0, ack_wait = 0, busy_wait = 0;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    br_valid = 1'b0;
    br_target = '0;
    dec_ready = 1'b1;
    m.mem_ready = 1'b0;
    m.mem_rdata = '0;
    mem_wait = cfg_lat_min;
    ack_wait = 0;
    busy_wait = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // memory responder, decoder model and random redirects for one cycle
  task automatic env_drive();
    br_valid = 1'b0;
    m.mem_ready = 1'b0;
    m.mem_rdata = $urandom;
    if (m.mem_rd) begin
      if (mem_wait == 0) begin
        m.mem_ready = 1'b1;
        m.mem_rdata = word_at(m.mem_addr);
        mem_wait = $urandom_range(cfg_lat_max, cfg_lat_min);
      end else begin
        mem_wait--;
      end
    end else begin
      mem_wait = $urandom_range(cfg_lat_max, cfg_lat_min);
      if (cfg_spurious && $urandom_range(3, 0) == 0) m.mem_ready = 1'b1;
    end
    if (cs) begin
      ack_wait = $urandom_range(cfg_ack_max, 0);
      busy_wait = $urandom_range(cfg_busy_max, cfg_busy_min);
    end
    if (ack_wait > 0) begin
      dec_ready = 1'b1;
      ack_wait--;
    end else if (busy_wait > 0) begin
      dec_ready = 1'b0;
      busy_wait--;
    end else begin
      dec_ready = 1'b1;
    end
    if (cfg_br_rate != 0 && $urandom_range(cfg_br_rate - 1, 0) == 0) begin
      br_valid = 1'b1;
      br_target = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    if (mem_rd_check(1'b0)) ;
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b expected 0", cs); end
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir: got %h expected 0", ir); end
    m.mem_ready = 1'b1;
    m.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (m.mem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd_held: got %b expected 0", m.mem_rd); end
    rst = 1'b0;
    m.mem_ready = 1'b0;
    #1;
    total++; if (m.mem_rd !== 1'b1) begin bad++; $display("FAIL first_req: got %b expected 1", m.mem_rd); end
    total++; if (m.mem_addr !== 16'h0000) begin bad++; $display("FAIL first_addr: got %h expected 0000", m.mem_addr); end
  endtask

  function automatic bit mem_rd_check(input logic want);
    total++;
    if (m.mem_rd !== want) begin
      bad++;
      $display("FAIL reset_mem_rd: got %b expected %b", m.mem_rd, want);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_basic_sequence();
    logic [31:0] got[$];
    int unsigned fetches = 0;
    bit pc_pending = 1'b0;
    cfg_lat_min = 1; cfg_lat_max = 1; cfg_ack_max = 0;
    cfg_busy_min = 1; cfg_busy_max = 1; cfg_br_rate = 0; cfg_spurious = 1'b0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pc_pending) begin
        pc_pending = 1'b0;
        total++; if (pc !== 16'd3) begin bad++; $display("FAIL basic_pc3: got %h expected 0003", pc); end
      end
      total++; if (cs !== m_cs) begin bad++; $display("FAIL basic_cs cyc %0d: got %b expected %b", i, cs, m_cs); end
      if (cs) got.push_back(ir);
      env_drive();
      if (m.mem_rd && m.mem_ready) begin
        fetches++;
        if (fetches == 3) pc_pending = 1'b1;
      end
    end
    total++;
    if (got.size() < 3) begin
      bad++;
      $display("FAIL basic_issues: got %0d expected >= 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got[i] !== word_at(16'(i))) begin
          bad++;
          $display("FAIL basic_ir%0d: got %h expected %h", i, got[i], word_at(16'(i)));
        end
      end
    end
  endtask

  task automatic test_slow_decoder();
    int unsigned fetches = 0, extra_cs = 0;
    apply_reset();
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0000);
    @(negedge clk);
    m.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL slow_cs0: got %b expected 1", cs); end
    total++; if (ir !== word_at(16'h0000)) begin bad++; $display("FAIL slow_ir0: got %h expected %h", ir, word_at(16'h0000)); end
    for (int i = 0; i < 10; i++) begin
      dec_ready = 1'b0;
      m.mem_ready = 1'b1;
      m.mem_rdata = word_at(m.mem_addr);
      if (m.mem_rd) fetches++;
      @(negedge clk);
      if (cs) extra_cs++;
    end
    total++; if (fetches !== 1) begin bad++; $display("FAIL slow_prefetch: got %0d expected 1", fetches); end
    total++; if (extra_cs !== 0) begin bad++; $display("FAIL slow_no_cs: got %0d expected 0", extra_cs); end
    total++; if (pc !== 16'h0002) begin bad++; $display("FAIL slow_pc: got %h expected 0002", pc); end
    total++; if (m.mem_rd !== 1'b0) begin bad++; $display("FAIL slow_rd: got %b expected 0", m.mem_rd); end
    dec_ready = 1'b1;
    m.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL slow_cs_early: got %b expected 0", cs); end
    @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL slow_cs1: got %b expected 1", cs); end
    total++; if (ir !== word_at(16'h0001)) begin bad++; $display("FAIL slow_ir1: got %h expected %h", ir, word_at(16'h0001)); end
    dec_ready = 1'b0;
  endtask

  task automatic test_branch_on_ready();
    apply_reset();
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0000);
    br_valid = 1'b1; br_target = 16'h0040;
    @(negedge clk);
    total++; if (pc !== 16'h0040) begin bad++; $display("FAIL br_pc: got %h expected 0040", pc); end
    total++; if (m.mem_addr !== 16'h0040) begin bad++; $display("FAIL br_addr: got %h expected 0040", m.mem_addr); end
    total++; if (m.mem_rd !== 1'b1) begin bad++; $display("FAIL br_rd: got %b expected 1", m.mem_rd); end
    br_valid = 1'b0;
    m.mem_rdata = word_at(16'h0040);
    @(negedge clk);
    total++; if (pc !== 16'h0041) begin bad++; $display("FAIL br_pc_inc: got %h expected 0041", pc); end
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL br_cs_early: got %b expected 0", cs); end
    m.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL br_cs: got %b expected 1", cs); end
    total++; if (ir !== word_at(16'h0040)) begin bad++; $display("FAIL br_ir: got %h expected %h", ir, word_at(16'h0040)); end
    dec_ready = 1'b0;
  endtask

  task automatic test_branch_in_idle();
    apply_reset();
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0000);
    @(negedge clk);
    total++; if (m.mem_rd !== 1'b0) begin bad++; $display("FAIL idle_br_full: got %b expected 0", m.mem_rd); end
    m.mem_ready = 1'b0;
    br_valid = 1'b1; br_target = 16'h0100; dec_ready = 1'b1;
    @(negedge clk);
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL idle_br_cs: got %b expected 0", cs); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL idle_br_ir: got %h expected 0", ir); end
    total++; if (pc !== 16'h0100) begin bad++; $display("FAIL idle_br_pc: got %h expected 0100", pc); end
    total++; if (m.mem_rd !== 1'b1) begin bad++; $display("FAIL idle_br_flush: got %b expected 1", m.mem_rd); end
    br_valid = 1'b0;
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0100);
    @(negedge clk);
    m.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL idle_br_cs2: got %b expected 1", cs); end
    total++; if (ir !== word_at(16'h0100)) begin bad++; $display("FAIL idle_br_ir2: got %h expected %h", ir, word_at(16'h0100)); end
    dec_ready = 1'b0;
  endtask

  task automatic test_reset_in_busy();
    apply_reset();
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0000);
    @(negedge clk);
    m.mem_ready = 1'b0;
    @(negedge clk);
    dec_ready = 1'b0;
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0001);
    @(negedge clk);
    m.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0002);
    @(negedge clk);
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL rstbusy_cs: got %b expected 0", cs); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL rstbusy_ir: got %h expected 0", ir); end
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL rstbusy_pc: got %h expected 0000", pc); end
    total++; if (m.mem_rd !== 1'b0) begin bad++; $display("FAIL rstbusy_rd: got %b expected 0", m.mem_rd); end
    rst = 1'b0;
    m.mem_ready = 1'b0;
    dec_ready = 1'b1;
    #1;
    total++; if (m.mem_rd !== 1'b1) begin bad++; $display("FAIL rstbusy_flush: got %b expected 1", m.mem_rd); end
    m.mem_ready = 1'b1; m.mem_rdata = word_at(16'h0000);
    @(negedge clk);
    m.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL rstbusy_idle: got %b expected 1", cs); end
    total++; if (ir !== word_at(16'h0000)) begin bad++; $display("FAIL rstbusy_ir2: got %h expected %h", ir, word_at(16'h0000)); end
    dec_ready = 1'b0;
  endtask

  task automatic test_reset_pc_wrap();
    @(negedge clk);
    rst2 = 1'b1; dec_ready2 = 1'b1; br_valid2 = 1'b0; m2.mem_ready = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    total++; if (m2.mem_rd !== 1'b1) begin bad++; $display("FAIL wrap_rd: got %b expected 1", m2.mem_rd); end
    total++; if (m2.mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr0: got %h expected ffff", m2.mem_addr); end
    m2.mem_ready = 1'b1; m2.mem_rdata = word_at(16'hFFFF);
    @(negedge clk);
    total++; if (pc2 !== 16'h0000) begin bad++; $display("FAIL wrap_pc: got %h expected 0000", pc2); end
    m2.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (cs2 !== 1'b1) begin bad++; $display("FAIL wrap_cs: got %b expected 1", cs2); end
    total++; if (ir2 !== word_at(16'hFFFF)) begin bad++; $display("FAIL wrap_ir: got %h expected %h", ir2, word_at(16'hFFFF)); end
    total++; if (m2.mem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_addr1: got %h expected 0000", m2.mem_addr); end
  endtask

  task automatic test_random_traffic(input string tag, input int unsigned n,
                                     input int unsigned lat_max, input int unsigned busy_max,
                                     input int unsigned br_rate);
    int unsigned issues = 0;
    int unsigned errs = 0;
    cfg_lat_min = 0; cfg_lat_max = lat_max; cfg_ack_max = 2;
    cfg_busy_min = 1; cfg_busy_max = busy_max; cfg_br_rate = br_rate; cfg_spurious = 1'b1;
    apply_reset();
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (pc !== 16'(m_pc) || m.mem_addr !== 16'(m_pc)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL %s_pc cyc %0d: got pc=%h addr=%h expected %h", tag, i, pc, m.mem_addr, 16'(m_pc));
      end
      total++;
      if (m.mem_rd !== logic'(m_buf.size() == 0)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL %s_rd cyc %0d: got %b expected %b", tag, i, m.mem_rd, m_buf.size() == 0);
      end
      total++;
      if (cs !== m_cs || ir !== m_ir) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL %s_issue cyc %0d: got cs=%b ir=%h expected cs=%b ir=%h", tag, i, cs, ir, m_cs, m_ir);
      end
      if (cs) issues++;
      env_drive();
    end
    total++;
    if (issues < 10) begin
      bad++;
      $display("FAIL %s_progress: got %0d issues expected >= 10", tag, issues);
    end
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b1; br_valid = 1'b0; br_target = '0;
    m.mem_ready = 1'b0; m.mem_rdata = '0;
    rst2 = 1'b1; dec_ready2 = 1'b1; br_valid2 = 1'b0; br_target2 = '0;
    m2.mem_ready = 1'b0; m2.mem_rdata = '0;
    test_reset();
    test_basic_sequence();
    test_slow_decoder();
    test_branch_on_ready();
    test_branch_in_idle();
    test_reset_in_busy();
    test_reset_pc_wrap();
    test_random_traffic("stream", 400, 2, 3, 0);
    test_random_traffic("slow", 400, 4, 12, 0);
    test_random_traffic("branchy", 800, 2, 4, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: ADDR_W, default 16, width of program counter and memory address.
REQ-002 Parameter: RESET_PC, default 0, program counter value after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  ADDR_W  word address of instruction fetch; equals pc.
REQ-006 mem_rd  output  1  fetch request, held until mem_ready.
REQ-007 mem_rdata  input  32  instruction word from memory, valid when mem_ready=1.
REQ-008 mem_ready  input  1  memory completion strobe, one cycle per word.
REQ-009 ir  output  32  instruction register presented to the decoder.
REQ-010 cs  output  1  decoder start, one-cycle pulse per issued instruction.
REQ-011 dec_ready  input  1  decoder ready/done (decoder's ready1): 1 = idle or finished.
REQ-012 br_valid  input  1  one-cycle redirect request.
REQ-013 br_target  input  ADDR_W  redirect address, sampled when br_valid=1.
REQ-014 pc  output  ADDR_W  address of the next word to be fetched.

Function
REQ-015 Fetch side and issue side SHALL share a one-entry prefetch buffer (buf, buf_valid).
REQ-016 mem_rd SHALL equal (!buf_valid && !rst); mem_addr SHALL equal pc at all times.
REQ-017 On a rising edge with mem_rd=1, mem_ready=1 and br_valid=0: buf<=mem_rdata, buf_valid<=1, pc<=pc+1.
REQ-018 pc increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-019 mem_ready while mem_rd=0 SHALL be ignored.
REQ-020 Issue FSM states: IDLE, ACK, BUSY.
REQ-021 IDLE: if buf_valid=1, dec_ready=1 and br_valid=0 -> ir<=buf, buf_valid<=0, cs<=1 for exactly the next cycle, go to ACK; otherwise stay.
REQ-022 ACK: cs=0; dec_ready=0 -> BUSY; otherwise stay (decoder has not yet acknowledged).
REQ-023 BUSY: dec_ready=1 -> IDLE; otherwise stay.
REQ-024 Minimum issue interval SHALL be 3 cycles (IDLE->ACK->BUSY->IDLE); the next cs SHALL occur no earlier than the first IDLE cycle with buf_valid=1.
REQ-025 ir SHALL hold its value from issue until the next issue; it SHALL NOT change in ACK or BUSY.
REQ-026 Fetch of the next word SHALL proceed while the issue FSM is in ACK or BUSY (prefetch overlap).
REQ-027 br_valid=1: pc<=br_target, buf_valid<=0; any mem_ready in the same cycle SHALL be discarded and pc SHALL NOT increment.
REQ-028 br_valid=1 in IDLE SHALL suppress issue that cycle (the wrong-path buffer is flushed, not issued).
REQ-029 br_valid SHALL NOT alter the issue FSM state or ir; the instruction already issued completes normally.
REQ-030 Cycle after br_valid: mem_rd=1, mem_addr=br_target.
REQ-031 Simultaneous buffer refill and consume cannot occur (mem_rd=0 while buf_valid=1); no bypass path from mem_rdata to ir.

Reset
REQ-032 rst=1 at a rising edge: pc<=RESET_PC, buf_valid<=0, ir<=0, cs<=0, issue FSM<=IDLE.
REQ-033 During rst=1: mem_rd=0, cs=0; first fetch request appears in the first cycle with rst=0.
REQ-034 rst asserted mid-fetch or mid-issue SHALL abort everything; memory data returned during rst SHALL be dropped.

Verification
REQ-035 Reset then mem_ready 1 cycle after each request, dec_ready=1 always low-pulsed 1 cycle after cs -> words from addresses 0,1,2 appear on ir in order, one cs each, pc=3 after third fetch.
REQ-036 Decoder busy 10 cycles after cs -> exactly one prefetch (mem_rd drops after buf fills), no second cs until dec_ready returns high.
REQ-037 br_valid with br_target=16'h0040 coinciding with mem_ready -> data discarded, pc=16'h0040, next mem_addr=16'h0040, next ir is word at 16'h0040.
REQ-038 br_valid in IDLE with buf_valid=1 and dec_ready=1 -> no cs that cycle, buffer flushed, target word issued later.
REQ-039 RESET_PC=16'hFFFF: first fetch at 16'hFFFF, second at 16'h0000.
REQ-040 rst asserted while in BUSY with buf_valid=1 -> next cycle IDLE, buf_valid=0, ir=0, cs=0, pc=RESET_PC.
